// File: rtl/key_event_fifo_pkg.sv
// Shared constants for the keypad front end: key codes, PS/2 scancodes,
// repeat-FSM state encodings and the scancode decode helpers.
package key_event_fifo_pkg;

  localparam logic [3:0] BCD_ZERO     = 4'd0;
  localparam logic [3:0] BCD_ONE      = 4'd1;
  localparam logic [3:0] BCD_TWO      = 4'd2;
  localparam logic [3:0] BCD_THREE    = 4'd3;
  localparam logic [3:0] BCD_FOUR     = 4'd4;
  localparam logic [3:0] BCD_FIVE     = 4'd5;
  localparam logic [3:0] BCD_SIX      = 4'd6;
  localparam logic [3:0] BCD_SEVEN    = 4'd7;
  localparam logic [3:0] BCD_EIGHT    = 4'd8;
  localparam logic [3:0] BCD_NINE     = 4'd9;
  localparam logic [3:0] BCD_TEN      = 4'd10;
  localparam logic [3:0] BCD_ELEVEN   = 4'd11;
  localparam logic [3:0] BCD_TWELVE   = 4'd12;
  localparam logic [3:0] BCD_THIRTEEN = 4'd13;
  localparam logic [3:0] KEY_BKSP     = 4'd14;
  localparam logic [3:0] KEY_ESC      = 4'd15;

  localparam logic [8:0] SC_0     = 9'h070;
  localparam logic [8:0] SC_1     = 9'h069;
  localparam logic [8:0] SC_2     = 9'h072;
  localparam logic [8:0] SC_3     = 9'h07A;
  localparam logic [8:0] SC_4     = 9'h06B;
  localparam logic [8:0] SC_5     = 9'h073;
  localparam logic [8:0] SC_6     = 9'h074;
  localparam logic [8:0] SC_7     = 9'h06C;
  localparam logic [8:0] SC_8     = 9'h075;
  localparam logic [8:0] SC_9     = 9'h07D;
  localparam logic [8:0] SC_A     = 9'h01C;
  localparam logic [8:0] SC_S     = 9'h01B;
  localparam logic [8:0] SC_M     = 9'h03A;
  localparam logic [8:0] SC_ENTER = 9'h05A;
  localparam logic [8:0] SC_BKSP  = 9'h066;
  localparam logic [8:0] SC_ESC   = 9'h076;

  localparam logic [1:0] KR_IDLE   = 2'd0;
  localparam logic [1:0] KR_DELAY  = 2'd1;
  localparam logic [1:0] KR_REPEAT = 2'd2;

  // Key code for a scancode; unmapped scancodes return zero (check sc_mapped).
  function automatic logic [3:0] sc_code(input logic [8:0] sc);
    case (sc)
      SC_0:     sc_code = BCD_ZERO;
      SC_1:     sc_code = BCD_ONE;
      SC_2:     sc_code = BCD_TWO;
      SC_3:     sc_code = BCD_THREE;
      SC_4:     sc_code = BCD_FOUR;
      SC_5:     sc_code = BCD_FIVE;
      SC_6:     sc_code = BCD_SIX;
      SC_7:     sc_code = BCD_SEVEN;
      SC_8:     sc_code = BCD_EIGHT;
      SC_9:     sc_code = BCD_NINE;
      SC_A:     sc_code = BCD_TEN;
      SC_S:     sc_code = BCD_ELEVEN;
      SC_M:     sc_code = BCD_TWELVE;
      SC_ENTER: sc_code = BCD_THIRTEEN;
      SC_BKSP:  sc_code = KEY_BKSP;
      SC_ESC:   sc_code = KEY_ESC;
      default:  sc_code = BCD_ZERO;
    endcase
  endfunction

  function automatic logic sc_mapped(input logic [8:0] sc);
    case (sc)
      SC_0, SC_1, SC_2, SC_3, SC_4, SC_5, SC_6, SC_7, SC_8, SC_9,
      SC_A, SC_S, SC_M, SC_ENTER, SC_BKSP, SC_ESC: sc_mapped = 1'b1;
      default: sc_mapped = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/key_sync_fifo.sv
// First-word-fall-through synchronous FIFO. A push into a full FIFO is
// accepted only when a pop frees the head in the same cycle; otherwise it
// is dropped and flagged on 'drop'.
module key_sync_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic                       pop,
  input  logic [WIDTH-1:0]           din,
  output logic [WIDTH-1:0]           head,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       drop
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign drop    = push & full & ~do_pop;
  assign head    = mem[rd_ptr];

  // Storage, pointers (wrap naturally since DEPTH is a power of 2) and count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/key_event_fifo.sv
// Keypad front end: decodes PS/2 make events into 4-bit key codes, optionally
// generates hold-to-repeat events, and queues everything in a FWFT FIFO.
module key_event_fifo
  import key_event_fifo_pkg::*;
#(
  parameter int DEPTH         = 4,
  parameter int REPEAT_EN     = 0,
  parameter int REPEAT_DELAY  = 50_000_000,
  parameter int REPEAT_PERIOD = 10_000_000
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [8:0]             last_change,
  input  logic                   key_valid,
  input  logic                   key_held,
  input  logic                   pop,
  output logic [3:0]             char,
  output logic                   char_valid,
  output logic [$clog2(DEPTH):0] count,
  output logic                   overflow,
  input  logic                   clr_ovf
);

  localparam int CMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int CW   = $clog2(CMAX);
  localparam logic [CW-1:0] DELAY_LAST  = CW'(REPEAT_DELAY - 1);
  localparam logic [CW-1:0] PERIOD_LAST = CW'(REPEAT_PERIOD - 1);

  logic [1:0]    state;
  logic [CW-1:0] cnt;
  logic [8:0]    latch;
  logic          accepted;
  logic          still_held;
  logic          rep_tick;
  logic          push;
  logic [3:0]    push_code;
  logic          fifo_empty;
  logic          fifo_full;
  logic          drop;

  // Press acceptance and repeat-tick detection; a press always wins, so the
  // two never push in the same cycle.
  always_comb begin
    accepted   = key_valid & key_held & sc_mapped(last_change);
    still_held = key_held & (last_change == latch);
    rep_tick   = 1'b0;
    if (!accepted && still_held) begin
      if (state == KR_DELAY)  rep_tick = (cnt == DELAY_LAST);
      if (state == KR_REPEAT) rep_tick = (cnt == PERIOD_LAST);
    end
    push      = accepted | rep_tick;
    push_code = accepted ? sc_code(last_change) : sc_code(latch);
  end

  // Hold-to-repeat FSM: IDLE -> DELAY on a press, DELAY -> REPEAT on the first
  // repeat, back to IDLE when the latched key is released or replaced.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= KR_IDLE;
      cnt   <= '0;
      latch <= '0;
    end else if (accepted && REPEAT_EN != 0) begin
      state <= KR_DELAY;
      cnt   <= '0;
      latch <= last_change;
    end else begin
      case (state)
        KR_DELAY, KR_REPEAT: begin
          if (!still_held) begin
            state <= KR_IDLE;
            cnt   <= '0;
          end else if (rep_tick) begin
            state <= KR_REPEAT;
            cnt   <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          state <= KR_IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

  // Sticky overflow flag; a drop in the same cycle as a clear keeps it set.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       overflow <= 1'b0;
    else if (drop)    overflow <= 1'b1;
    else if (clr_ovf) overflow <= 1'b0;
  end

  key_sync_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (4)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .pop   (pop),
    .din   (push_code),
    .head  (char),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (count),
    .drop  (drop)
  );

  assign char_valid = ~fifo_empty;

endmodule

// File: tb/tb_key_event_fifo.sv
// Testbench for key_event_fifo: queue-based reference model checked every
// cycle, plus directed scenarios with hand-computed expectations.
module tb_key_event_fifo;

  localparam int DEPTH = 4;
  localparam int DLY   = 8;
  localparam int PER   = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic [8:0] last_change = '0;
  logic       key_valid = 1'b0;
  logic       key_held = 1'b0;
  logic       pop = 1'b0;
  logic       clr_ovf = 1'b0;
  logic [3:0] char;
  logic       char_valid;
  logic [2:0] count;
  logic       overflow;

  always #5 clk = ~clk;

  key_event_fifo #(
    .DEPTH         (DEPTH),
    .REPEAT_EN     (1),
    .REPEAT_DELAY  (DLY),
    .REPEAT_PERIOD (PER)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .last_change (last_change),
    .key_valid   (key_valid),
    .key_held    (key_held),
    .pop         (pop),
    .char        (char),
    .char_valid  (char_valid),
    .count       (count),
    .overflow    (overflow),
    .clr_ovf     (clr_ovf)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Scancode table: code for a make, or -1 when the key is not on the keypad.
  function automatic int map_sc(input logic [8:0] sc);
    case (sc)
      9'h070: return 0;   9'h069: return 1;   9'h072: return 2;
      9'h07A: return 3;   9'h06B: return 4;   9'h073: return 5;
      9'h074: return 6;   9'h06C: return 7;   9'h075: return 8;
      9'h07D: return 9;   9'h01C: return 10;  9'h01B: return 11;
      9'h03A: return 12;  9'h05A: return 13;  9'h066: return 14;
      9'h076: return 15;
      default: return -1;
    endcase
  endfunction

  // Reference model: queue of codes, sticky flag, and a countdown to the next
  // repeat of the held key.
  int         mq[$];
  bit         m_ovf;
  bit         rep_on;
  logic [8:0] rep_sc;
  int         rem;
  int         m_code;
  bit         m_push;
  bit         m_pop;
  bit         m_drop;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mq.delete();
      m_ovf  = 0;
      rep_on = 0;
      rep_sc = '0;
      rem    = 0;
    end else begin
      m_push = 0;
      m_code = 0;
      if (key_valid && key_held && map_sc(last_change) >= 0) begin
        m_push = 1;
        m_code = map_sc(last_change);
        rep_on = 1;
        rep_sc = last_change;
        rem    = DLY;
      end else if (rep_on) begin
        if (!key_held || last_change != rep_sc) begin
          rep_on = 0;
        end else begin
          rem--;
          if (rem == 0) begin
            m_push = 1;
            m_code = map_sc(rep_sc);
            rem    = PER;
          end
        end
      end
      m_pop  = pop && (mq.size() > 0);
      m_drop = m_push && (mq.size() == DEPTH) && !m_pop;
      if (m_pop) void'(mq.pop_front());
      if (m_push && !m_drop) mq.push_back(m_code);
      if (m_drop) m_ovf = 1;
      else if (clr_ovf) m_ovf = 0;
    end
  end

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    check("model.count", int'(count), mq.size());
    check("model.char_valid", int'(char_valid), int'(mq.size() != 0));
    check("model.overflow", int'(overflow), int'(m_ovf));
    if (mq.size() != 0) check("model.char", int'(char), mq[0]);
  end

  task automatic press(input logic [8:0] sc, input logic with_pop);
    @(negedge clk);
    last_change = sc; key_valid = 1'b1; key_held = 1'b1; pop = with_pop;
    @(negedge clk);
    key_valid = 1'b0; key_held = 1'b0; pop = 1'b0;
  endtask

  task automatic brk(input logic [8:0] sc);
    @(negedge clk);
    last_change = sc; key_valid = 1'b1; key_held = 1'b0;
    @(negedge clk);
    key_valid = 1'b0;
  endtask

  task automatic do_pop();
    @(negedge clk);
    pop = 1'b1;
    @(negedge clk);
    pop = 1'b0;
  endtask

  int seen;

  initial begin
    // Reset state
    #2 rst_n = 1'b0;
    #1;
    check("reset.char", int'(char), 0);
    check("reset.char_valid", int'(char_valid), 0);
    check("reset.count", int'(count), 0);
    check("reset.overflow", int'(overflow), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Single press of 1 then its break
    press(9'h069, 1'b0);
    check("t1.char", int'(char), 1);
    check("t1.count", int'(count), 1);
    brk(9'h069);
    check("t1.break_count", int'(count), 1);
    do_pop();
    check("t1.pop_valid", int'(char_valid), 0);

    // Same key twice, then an unmapped scancode
    press(9'h073, 1'b0);
    brk(9'h073);
    press(9'h073, 1'b0);
    brk(9'h073);
    check("t2.count", int'(count), 2);
    check("t2.head0", int'(char), 5);
    press(9'h029, 1'b0);
    check("t2.unmapped_count", int'(count), 2);
    do_pop();
    check("t2.head1", int'(char), 5);
    do_pop();
    check("t2.empty", int'(count), 0);

    // Overflow: five presses into four slots, then push with pop while full
    press(9'h069, 1'b0);
    press(9'h072, 1'b0);
    press(9'h07A, 1'b0);
    press(9'h06B, 1'b0);
    press(9'h073, 1'b0);
    check("t3.count_full", int'(count), 4);
    check("t3.overflow", int'(overflow), 1);
    check("t3.head_first", int'(char), 1);
    press(9'h074, 1'b1);
    check("t3.count_pushpop", int'(count), 4);
    check("t3.overflow_kept", int'(overflow), 1);
    check("t3.head_second", int'(char), 2);
    @(negedge clk); clr_ovf = 1'b1;
    @(negedge clk); clr_ovf = 1'b0;
    check("t3.clr_ovf", int'(overflow), 0);
    repeat (4) do_pop();
    check("t3.drained", int'(count), 0);

    // Hold A for 20 cycles with continuous pop: press + 4 repeats of code 10
    seen = 0;
    @(negedge clk);
    last_change = 9'h01C; key_valid = 1'b1; key_held = 1'b1; pop = 1'b1;
    for (int i = 0; i < 32; i++) begin
      @(negedge clk);
      key_valid = 1'b0;
      if (i == 20) key_held = 1'b0;
      if (char_valid && char == 4'd10) seen++;
    end
    pop = 1'b0;
    check("t4.a_events", seen, 5);
    check("t4.empty", int'(count), 0);

    // Hold 3 under repeat, then press M: 3 repeats stop, M delay restarts
    @(negedge clk);
    last_change = 9'h07A; key_valid = 1'b1; key_held = 1'b1;
    for (int i = 0; i <= 18; i++) begin
      @(negedge clk);
      key_valid = 1'b0;
      if (i == 9) begin
        last_change = 9'h03A; key_valid = 1'b1; key_held = 1'b1;
      end
      if (i == 10) check("t5.after_m_press", int'(count), 3);
      if (i == 17) check("t5.before_m_repeat", int'(count), 3);
      if (i == 18) check("t5.m_repeat", int'(count), 4);
    end
    key_held = 1'b0;
    check("t5.q0", int'(char), 3);
    do_pop();
    check("t5.q1", int'(char), 3);
    do_pop();
    check("t5.q2", int'(char), 12);
    do_pop();
    check("t5.q3", int'(char), 12);
    do_pop();
    check("t5.empty", int'(count), 0);

    // Reset with three entries queued while in REPEAT
    press(9'h06C, 1'b0);
    @(negedge clk);
    last_change = 9'h07A; key_valid = 1'b1; key_held = 1'b1;
    @(negedge clk);
    key_valid = 1'b0;
    repeat (8) @(negedge clk);
    check("t6.queued", int'(count), 3);
    #2 rst_n = 1'b0;
    #1;
    check("t6.rst_char", int'(char), 0);
    check("t6.rst_valid", int'(char_valid), 0);
    check("t6.rst_count", int'(count), 0);
    check("t6.rst_overflow", int'(overflow), 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (12) @(negedge clk);
    check("t6.no_push_after_reset", int'(count), 0);
    key_held = 1'b0;
    repeat (2) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/key_event_fifo.md
# key_event_fifo

Keypad front end that turns keyboard make events into 4-bit key codes and queues them for the calculator/control FSM. It sits between the PS/2 keyboard decoder (`last_change`, `key_valid`, per-key held status) and any consumer that pops one key at a time. It improves on the single toggle-flag scheme in four ways:
- Unmapped scancodes are dropped, not aliased to zero.
- Repeated presses of the same key are accepted.
- Events are buffered in a first-word-fall-through FIFO.
- Optional hold-to-repeat is supported.

## Interface
Parameters:
- `DEPTH`, 4: FIFO entries; must be a power of 2 and ≥2.
- `REPEAT_EN`, 0: 1 enables hold-to-repeat.
- `REPEAT_DELAY`, 50_000_000: cycles from accepted press to first repeat; must be ≥2.
- `REPEAT_PERIOD`, 10_000_000: cycles between subsequent repeats; must be ≥2.

Ports:
- `clk`, in, 1: single clock for the whole block.
- `rst_n`, in, 1: reset, asynchronous and active-low.
- `last_change`, in, 9: scancode of the most recent keyboard event.
- `key_valid`, in, 1: one-cycle pulse per make or break event on `last_change`.
- `key_held`, in, 1: level, 1 while the key `last_change` is pressed.
- `pop`, in, 1: consumer takes the head entry this cycle.
- `char`, out, 4: head key code; valid only when `char_valid` is 1.
- `char_valid`, out, 1: FIFO is non-empty.
- `count`, out, $clog2(DEPTH)+1: current number of entries.
- `overflow`, out, 1: sticky; set when a push is dropped.
- `clr_ovf`, in, 1: clears `overflow`.

## Operation
- Decode map:
  - Scancodes 70,69,72,7A,6B,73,74,6C,75,7D map to codes 0–9.
  - 1C (A) → 10, 1B (S) → 11, 3A (M) → 12, 5A (enter) → 13.
  - 66 (backspace) → 14, 76 (esc) → 15.
  - Any other scancode is unmapped.
- Accepted press: `key_valid` & `key_held` & mapped. It pushes the code. Break events (`key_held`=0) never push.
- Repeat FSM, states IDLE / DELAY / REPEAT, with an internal cycle counter and a latched scancode:
  - IDLE → DELAY on an accepted press while `REPEAT_EN`=1. Latch `last_change`; counter=0.
  - DELAY: counter increments each cycle. When it reaches REPEAT_DELAY−1, push the latched code, counter=0, go to REPEAT.
  - REPEAT: when the counter reaches REPEAT_PERIOD−1, push, counter=0, stay in REPEAT.
  - From DELAY or REPEAT: `key_held`=0 or `last_change` ≠ latch → IDLE with no push.
  - From DELAY or REPEAT: a new accepted press restarts DELAY with the new latch. That press pushes exactly once.
  - With `REPEAT_EN`=0 the FSM stays in IDLE.
- FIFO rules:
  - Push when not full: write at the tail.
  - Push when full with `pop`=1: both happen; count unchanged; no overflow.
  - Push when full with `pop`=0: entry dropped; `overflow`←1.
  - Pop when empty: ignored.
  - Pointer wrap is modulo DEPTH.
- `overflow`: `clr_ovf` clears it. If a drop and `clr_ovf` occur in the same cycle, the set wins.
- At most one push per cycle. A press and a repeat tick can never coincide, because a press restarts the counter.

## Timing
- Reset values: `char`=0, `char_valid`=0, `count`=0, `overflow`=0, FSM=IDLE, counter=0, latch=0, pointers=0.
- Push at edge N → `char_valid`=1 and `char` valid after edge N (visible in cycle N+1). First-word-fall-through: no read latency.
- Pop at edge N → the next head appears after edge N.
- `count` is registered and updates on the same edge as the push/pop.
- First repeat push occurs REPEAT_DELAY cycles after the press push; later repeats are REPEAT_PERIOD cycles apart.
- Reset asserted mid-hold or mid-queue clears everything immediately; queued entries are lost.

## Structure
- Shared include `global.v`:
  - Keep the existing `BCD_ZERO`..`BCD_THIRTEEN`.
  - Add `KEY_BKSP`=4'd14 and `KEY_ESC`=4'd15.
  - Add scancode macros `SC_0`..`SC_9`, `SC_A`, `SC_S`, `SC_M`, `SC_ENTER`, `SC_BKSP`, `SC_ESC`.
  - Add FSM state encodings `KR_IDLE`, `KR_DELAY`, `KR_REPEAT`.
- Sub-module `key_sync_fifo` (parameters DEPTH and WIDTH=4): push/pop/full/empty/count/head. The decode and the FSM stay in the top level.

## Test plan
- Press 1 (69, `key_held`=1), then its break: exactly one entry; `char`=1 on the cycle after the pulse; `pop` → `char_valid`=0.
- Press 5 twice with a break between: two entries, both 5. Press scancode 0x29 (unmapped): no entry.
- DEPTH=4, push 5 presses with no pop: `count`=4, `overflow`=1, head=first key. On the cycle the FIFO is full, push with `pop`=1: `count` stays 4, `overflow` unchanged. `clr_ovf` → 0.
- REPEAT_EN=1, DELAY=8, PERIOD=4, hold A for 20 cycles: pushes at press, +8, +12, +16, +20 (values 10); release → no further pushes.
- Hold 3 under repeat, then press M: M pushed once, the 3 repeats stop, and the M delay restarts from 0.
- Assert `rst_n`=0 with 3 entries queued and in state REPEAT: all outputs 0 asynchronously; after release, no push until the next `key_valid`.
